// File: rtl/seg_7_scan_decode.sv
// Recovers per-digit BCD values from a multiplexed 7-segment display bus.
// Each digit is debounced independently; illegal patterns and multi-hot selects are flagged.
module seg_7_scan_decode #(
  parameter int unsigned N_DIG      = 4,
  parameter int unsigned STABLE_CNT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [0:6]         seg_7,
  input  logic [N_DIG-1:0]   dig_sel,
  input  logic               clr_err,
  output logic [4*N_DIG-1:0] bcd,
  output logic [N_DIG-1:0]   digit_valid,
  output logic               update,
  output logic               pat_err,
  output logic               sel_err
);

  localparam logic [7:0]       StableMax = 8'(STABLE_CNT);
  localparam logic [N_DIG-1:0] SelOne    = 1;

  logic [0:6]         seg_m, s_seg;
  logic [N_DIG-1:0]   sel_m, s_sel, sel_q;
  logic [0:6]         cand_q [N_DIG];
  logic [0:6]         cand_d [N_DIG];
  logic [7:0]         cnt_q  [N_DIG];
  logic [7:0]         cnt_d  [N_DIG];
  logic [4*N_DIG-1:0] bcd_q, bcd_d;
  logic [N_DIG-1:0]   valid_q, valid_d;
  logic               update_q, update_d;
  logic               pat_err_q, pat_err_d;
  logic               sel_err_q, sel_err_d;

  logic       sel_onehot, sel_multi, sel_stable, sample;
  logic       pat_legal, pat_blank, pat_set;
  logic [3:0] pat_val;

  assign sel_onehot = (s_sel != '0) && ((s_sel & (s_sel - SelOne)) == '0);
  assign sel_multi  = (s_sel != '0) && !sel_onehot;
  assign sel_stable = (s_sel == sel_q);
  // The first cycle after any select change is a blanking cycle and never sampled.
  assign sample     = sel_onehot && sel_stable;

  always_comb begin
    pat_val   = 4'd0;
    pat_legal = 1'b1;
    pat_blank = 1'b0;
    case (s_seg)
      7'b1111110: pat_val = 4'd0;
      7'b0110000: pat_val = 4'd1;
      7'b1101101: pat_val = 4'd2;
      7'b1111001: pat_val = 4'd3;
      7'b0110011: pat_val = 4'd4;
      7'b1011011: pat_val = 4'd5;
      7'b1011111: pat_val = 4'd6;
      7'b1110000: pat_val = 4'd7;
      7'b1111111: pat_val = 4'd8;
      7'b1110011: pat_val = 4'd9;
      7'b0000000: begin
        pat_legal = 1'b0;
        pat_blank = 1'b1;
      end
      default:    pat_legal = 1'b0;
    endcase
  end

  always_comb begin
    bcd_d    = bcd_q;
    valid_d  = valid_q;
    update_d = 1'b0;
    pat_set  = 1'b0;
    for (int i = 0; i < N_DIG; i++) begin
      cand_d[i] = cand_q[i];
      cnt_d[i]  = cnt_q[i];
      if (sample && s_sel[i]) begin
        if (s_seg == cand_q[i]) begin
          // Saturated counters hold, so a steady digit is accepted only once.
          if (cnt_q[i] != StableMax) begin
            cnt_d[i] = cnt_q[i] + 8'd1;
            if (cnt_d[i] == StableMax) begin
              bcd_d[4*i +: 4] = pat_legal ? pat_val : 4'd0;
              valid_d[i]      = pat_legal;
              pat_set         = !pat_legal && !pat_blank;
              update_d        = (bcd_d[4*i +: 4] != bcd_q[4*i +: 4]) ||
                                (valid_d[i] != valid_q[i]);
            end
          end
        end else begin
          cand_d[i] = s_seg;
          cnt_d[i]  = 8'd1;
        end
      end
    end
    pat_err_d = pat_set | (pat_err_q & ~clr_err);
    sel_err_d = (sel_multi & sel_stable) | (sel_err_q & ~clr_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_m     <= '0;
      s_seg     <= '0;
      sel_m     <= '0;
      s_sel     <= '0;
      sel_q     <= '0;
      bcd_q     <= '0;
      valid_q   <= '0;
      update_q  <= 1'b0;
      pat_err_q <= 1'b0;
      sel_err_q <= 1'b0;
      for (int i = 0; i < N_DIG; i++) begin
        cand_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      seg_m     <= seg_7;
      s_seg     <= seg_m;
      sel_m     <= dig_sel;
      s_sel     <= sel_m;
      sel_q     <= s_sel;
      bcd_q     <= bcd_d;
      valid_q   <= valid_d;
      update_q  <= update_d;
      pat_err_q <= pat_err_d;
      sel_err_q <= sel_err_d;
      for (int i = 0; i < N_DIG; i++) begin
        cand_q[i] <= cand_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  assign bcd         = bcd_q;
  assign digit_valid = valid_q;
  assign update      = update_q;
  assign pat_err     = pat_err_q;
  assign sel_err     = sel_err_q;

endmodule

// File: tb/tb_seg_7_scan_decode.sv
// Directed bench for seg_7_scan_decode (N_DIG=4, STABLE_CNT=3): decode table plus
// hand-written latency, scan, glitch, error and reset sequences.
module tb_seg_7_scan_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:6]  seg_7;
  logic [3:0]  dig_sel;
  logic        clr_err;
  logic [15:0] bcd;
  logic [3:0]  digit_valid;
  logic        update;
  logic        pat_err;
  logic        sel_err;

  int checks   = 0;
  int failures = 0;
  int upd_total = 0;
  int upd_base;

  seg_7_scan_decode #(
    .N_DIG      (4),
    .STABLE_CNT (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_7       (seg_7),
    .dig_sel     (dig_sel),
    .clr_err     (clr_err),
    .bcd         (bcd),
    .digit_valid (digit_valid),
    .update      (update),
    .pat_err     (pat_err),
    .sel_err     (sel_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (update === 1'b1) upd_total <= upd_total + 1;

  typedef struct {
    logic [3:0] sel;
    int         d;
    logic [0:6] seg;
    logic [3:0] exp_bcd;
    logic       exp_valid;
    logic       exp_perr;
  } vec_t;

  vec_t vecs [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{4'b0001, 0, 7'b1111110, 4'd0, 1'b1, 1'b0};
    vecs[1]  = '{4'b0010, 1, 7'b0110000, 4'd1, 1'b1, 1'b0};
    vecs[2]  = '{4'b0100, 2, 7'b1101101, 4'd2, 1'b1, 1'b0};
    vecs[3]  = '{4'b1000, 3, 7'b1111001, 4'd3, 1'b1, 1'b0};
    vecs[4]  = '{4'b0001, 0, 7'b0110011, 4'd4, 1'b1, 1'b0};
    vecs[5]  = '{4'b0010, 1, 7'b1011011, 4'd5, 1'b1, 1'b0};
    vecs[6]  = '{4'b0100, 2, 7'b1011111, 4'd6, 1'b1, 1'b0};
    vecs[7]  = '{4'b1000, 3, 7'b1111111, 4'd8, 1'b1, 1'b0};
    vecs[8]  = '{4'b0001, 0, 7'b1110011, 4'd9, 1'b1, 1'b0};
    vecs[9]  = '{4'b0010, 1, 7'b0000000, 4'd0, 1'b0, 1'b0};
    vecs[10] = '{4'b0100, 2, 7'b1000000, 4'd0, 1'b0, 1'b1};
    vecs[11] = '{4'b1000, 3, 7'b0000001, 4'd0, 1'b0, 1'b1};
    vecs[12] = '{4'b0001, 0, 7'b0111111, 4'd0, 1'b0, 1'b1};

    // Reset held with random bus activity, then idle after release.
    rst = 1'b1; clr_err = 1'b0; seg_7 = '0; dig_sel = '0;
    for (int k = 0; k < 5; k++) begin
      seg_7   = 7'($urandom);
      dig_sel = 4'($urandom);
      tick();
      check("reset_outputs", {bcd, digit_valid, update, pat_err, sel_err}, '0);
    end
    seg_7 = '0; dig_sel = '0;
    rst = 1'b0;
    upd_base = upd_total;
    cycles(10);
    check("idle_outputs", {bcd, digit_valid, update, pat_err, sel_err}, '0);
    check("idle_updates", upd_total - upd_base, 0);

    // Single digit latency: accept lands exactly 6 edges after the inputs.
    dig_sel = 4'b0001; seg_7 = 7'b1111001;
    upd_base = upd_total;
    cycles(5);
    check("lat_before_update", update, 1'b0);
    check("lat_before_valid", digit_valid, 4'b0000);
    tick();
    check("lat_update", update, 1'b1);
    check("lat_bcd", bcd[3:0], 4'd3);
    check("lat_valid", digit_valid, 4'b0001);
    cycles(4);
    check("lat_update_count", upd_total - upd_base, 1);

    // Full scan, then a repeat round that must not produce updates.
    upd_base = upd_total;
    dig_sel = 4'b0001; seg_7 = 7'b1110000; cycles(8);
    dig_sel = 4'b0010; seg_7 = 7'b1101101; cycles(8);
    dig_sel = 4'b0100; seg_7 = 7'b1110011; cycles(8);
    dig_sel = 4'b1000; seg_7 = 7'b1111110; cycles(8);
    check("scan_bcd", bcd, 16'h0927);
    check("scan_valid", digit_valid, 4'b1111);
    check("scan_updates", upd_total - upd_base, 4);
    upd_base = upd_total;
    dig_sel = 4'b0001; seg_7 = 7'b1110000; cycles(8);
    dig_sel = 4'b0010; seg_7 = 7'b1101101; cycles(8);
    dig_sel = 4'b0100; seg_7 = 7'b1110011; cycles(8);
    dig_sel = 4'b1000; seg_7 = 7'b1111110; cycles(8);
    check("rescan_bcd", bcd, 16'h0927);
    check("rescan_updates", upd_total - upd_base, 0);

    // Short glitch on a held digit is filtered.
    upd_base = upd_total;
    dig_sel = 4'b0001; seg_7 = 7'b1110000; cycles(8);
    seg_7 = 7'b1111111; cycles(2);
    seg_7 = 7'b1110000; cycles(8);
    check("glitch_bcd", bcd, 16'h0927);
    check("glitch_updates", upd_total - upd_base, 0);
    check("glitch_pat_err", pat_err, 1'b0);

    // Illegal pattern on digit 1, clear, then a stable multi-hot select.
    upd_base = upd_total;
    dig_sel = 4'b0010; seg_7 = 7'b1001001; cycles(8);
    check("illegal_valid", digit_valid, 4'b1101);
    check("illegal_bcd", bcd, 16'h0907);
    check("illegal_pat_err", pat_err, 1'b1);
    check("illegal_updates", upd_total - upd_base, 1);
    pulse_clr();
    check("clr_pat_err", pat_err, 1'b0);
    upd_base = upd_total;
    dig_sel = 4'b0011; cycles(4);
    check("multihot_sel_err", sel_err, 1'b1);
    check("multihot_bcd", {bcd, digit_valid}, {16'h0907, 4'b1101});
    check("multihot_updates", upd_total - upd_base, 0);
    pulse_clr();
    check("clr_vs_set_sel_err", sel_err, 1'b1);
    dig_sel = 4'b0000; cycles(3);
    pulse_clr();
    check("clr_sel_err", sel_err, 1'b0);

    // Decode table across digits.
    for (int v = 0; v < 13; v++) begin
      dig_sel = vecs[v].sel; seg_7 = vecs[v].seg;
      cycles(8);
      check($sformatf("vec%0d_bcd", v), bcd[4*vecs[v].d +: 4], vecs[v].exp_bcd);
      check($sformatf("vec%0d_valid", v), digit_valid[vecs[v].d], vecs[v].exp_valid);
      check($sformatf("vec%0d_pat_err", v), pat_err, vecs[v].exp_perr);
      pulse_clr();
    end

    // Reset asserted mid-accept, then a full-latency re-accept.
    dig_sel = 4'b0010; seg_7 = 7'b1111111;
    cycles(5);
    rst = 1'b1;
    #2;
    check("midrst_outputs", {bcd, digit_valid, update, pat_err, sel_err}, '0);
    cycles(2);
    rst = 1'b0;
    cycles(5);
    check("postrst_early_valid", digit_valid, 4'b0000);
    check("postrst_early_update", update, 1'b0);
    tick();
    check("postrst_update", update, 1'b1);
    check("postrst_bcd", {bcd, digit_valid}, {16'h0080, 4'b0010});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
